// File: rtl/out_stream_sched.sv
// rtl/out_stream_sched.sv - layer sequencer for the output buffer
// Gives one result engine write ownership, then drains the buffer to the DMA stream.
module out_stream_sched #(
   parameter int DATA_WIDTH = 256,
   parameter int CNT_WIDTH  = 17
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Start,
   input  logic [CNT_WIDTH-1:0]  Cfg_Beats,
   input  logic                  Cfg_Src,
   input  logic [DATA_WIDTH-1:0] S0_Data,
   input  logic                  S0_Valid,
   output logic                  S0_Ready,
   input  logic [DATA_WIDTH-1:0] S1_Data,
   input  logic                  S1_Valid,
   output logic                  S1_Ready,
   output logic [DATA_WIDTH-1:0] B_Data,
   output logic                  B_Valid,
   input  logic                  B_Ready,
   output logic                  B_Last,
   input  logic [DATA_WIDTH-1:0] R_Data,
   input  logic                  R_Valid,
   output logic                  R_Ready,
   output logic [DATA_WIDTH-1:0] M_Data,
   output logic                  M_Valid,
   input  logic                  M_Ready,
   output logic                  M_Last,
   output logic                  Busy,
   output logic                  Done,
   output logic                  Err
);

   typedef enum logic [2:0] {
      S_IDLE, S_FILL, S_FLUSH, S_WAIT, S_DRAIN, S_DONE
   } state_t;

   // Largest legal layer is 2**(CNT_WIDTH-1) beats, i.e. only the top bit set.
   localparam logic [CNT_WIDTH-1:0] MAX_BEATS = {1'b1, {(CNT_WIDTH-1){1'b0}}};
   localparam logic [CNT_WIDTH-1:0] ONE       = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   beats_q, beats_d;
   logic                   src_q, src_d;
   logic [CNT_WIDTH-1:0]   wr_cnt_q, wr_cnt_d;
   logic [CNT_WIDTH-1:0]   rd_cnt_q, rd_cnt_d;
   logic                   err_q, err_d;

   logic                   cfg_ok;
   logic [CNT_WIDTH-1:0]   last_idx;
   logic                   wr_fire;

   assign cfg_ok   = (Cfg_Beats != '0) && (Cfg_Beats <= MAX_BEATS);
   assign last_idx = beats_q - ONE;
   assign Busy     = (state_q != S_IDLE);
   assign Err      = err_q;

   always_comb begin
      state_d  = state_q;
      beats_d  = beats_q;
      src_d    = src_q;
      wr_cnt_d = wr_cnt_q;
      rd_cnt_d = rd_cnt_q;
      err_d    = Start && !((state_q == S_IDLE) && cfg_ok);
      wr_fire  = 1'b0;
      B_Data   = '0;
      B_Valid  = 1'b0;
      B_Last   = 1'b0;
      S0_Ready = 1'b0;
      S1_Ready = 1'b0;
      R_Ready  = 1'b0;
      M_Data   = '0;
      M_Valid  = 1'b0;
      M_Last   = 1'b0;
      Done     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (Start && cfg_ok) begin
               beats_d  = Cfg_Beats;
               src_d    = Cfg_Src;
               wr_cnt_d = '0;
               rd_cnt_d = '0;
               state_d  = S_FILL;
            end
         end
         S_FILL: begin
            B_Data   = src_q ? S1_Data  : S0_Data;
            B_Valid  = src_q ? S1_Valid : S0_Valid;
            S0_Ready = !src_q && B_Ready;
            S1_Ready = src_q && B_Ready;
            wr_fire  = (src_q ? S1_Valid : S0_Valid) && B_Ready;
            if (wr_fire) begin
               wr_cnt_d = wr_cnt_q + ONE;
               if (wr_cnt_q == last_idx) state_d = S_FLUSH;
            end
         end
         S_FLUSH: begin
            B_Last  = 1'b1;
            state_d = S_WAIT;
         end
         // The buffer registers its drain start, so wait for data to actually appear.
         S_WAIT: begin
            if (R_Valid) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            M_Data  = R_Data;
            M_Valid = R_Valid;
            R_Ready = M_Ready;
            M_Last  = R_Valid && (rd_cnt_q == last_idx);
            if (R_Valid && M_Ready) begin
               rd_cnt_d = rd_cnt_q + ONE;
               if (rd_cnt_q == last_idx) state_d = S_DONE;
            end
         end
         S_DONE: begin
            Done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         beats_q  <= '0;
         src_q    <= 1'b0;
         wr_cnt_q <= '0;
         rd_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         beats_q  <= beats_d;
         src_q    <= src_d;
         wr_cnt_q <= wr_cnt_d;
         rd_cnt_q <= rd_cnt_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: doc/out_stream_sched.md
Name: out_stream_sched

Overview:
- Layer-level sequencer for the 256-bit output buffer (65536-deep URAM FIFO with Last-triggered drain).
- Per layer, grants buffer write ownership to one of two result engines (conv = source 0, pool = source 1).
- Counts the configured number of write beats, then pulses the buffer's Last input.
- Drains the buffer to the DMA stream, tags the final beat with M_Last, and reports Done.

Parameters:
- DATA_WIDTH, 256, stream data width.
- CNT_WIDTH, 17, beat counter width; holds 1..65536.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- Start, input, 1, one-cycle pulse; latches the Cfg_* inputs.
- Cfg_Beats, input, CNT_WIDTH, beats in this layer; valid range 1..65536.
- Cfg_Src, input, 1, write owner: 0 = conv, 1 = pool.
- S0_Data, input, DATA_WIDTH, conv result data.
- S0_Valid, input, 1, conv result valid.
- S0_Ready, output, 1, conv result ready.
- S1_Data, input, DATA_WIDTH, pool result data.
- S1_Valid, input, 1, pool result valid.
- S1_Ready, output, 1, pool result ready.
- B_Data, output, DATA_WIDTH, data to the buffer write side.
- B_Valid, output, 1, buffer write valid.
- B_Ready, input, 1, buffer write ready.
- B_Last, output, 1, one-cycle pulse to the buffer's Last input.
- R_Data, input, DATA_WIDTH, buffer read data.
- R_Valid, input, 1, buffer read valid.
- R_Ready, output, 1, buffer read ready.
- M_Data, output, DATA_WIDTH, DMA stream data.
- M_Valid, output, 1, DMA stream valid.
- M_Ready, input, 1, DMA stream ready.
- M_Last, output, 1, marks the final beat of the layer.
- Busy, output, 1, high whenever the state is not IDLE.
- Done, output, 1, one-cycle pulse at layer end.
- Err, output, 1, one-cycle pulse on a rejected Start.

Behaviour:
- Reset: state IDLE; wr_cnt = rd_cnt = 0; all registered outputs 0 (B_Last, Done, Err, Busy).
- Reset mid-layer returns to IDLE in the next cycle; no partial-count carry-over.
- States: IDLE -> FILL -> FLUSH -> WAIT -> DRAIN -> DONE -> IDLE.
- IDLE:
  - Start with Cfg_Beats in 1..65536 latches beats and src, clears counters, enters FILL.
  - Start with Cfg_Beats = 0 pulses Err next cycle and stays IDLE.
- Start in any state other than IDLE: ignored; Err pulses next cycle.
- FILL, datapath (combinational, zero latency):
  - B_Data = selected S*_Data; B_Valid = selected S*_Valid.
  - Selected S*_Ready = B_Ready; unselected S*_Ready = 0.
- FILL, counting:
  - Write handshake: B_Valid && B_Ready; each one increments wr_cnt.
  - The handshake with wr_cnt == beats-1 moves the state to FLUSH.
  - Beats never exceeds FIFO depth, so full is never reached.
- Outside FILL: B_Valid = 0 and both S*_Ready = 0.
- FLUSH: B_Last = 1 for exactly one cycle, then WAIT.
- WAIT: holds until R_Valid = 1, covering the buffer's registered state change and registered M_Valid; then DRAIN.
- DRAIN, datapath (combinational):
  - M_Data = R_Data; M_Valid = R_Valid; R_Ready = M_Ready.
- DRAIN, counting:
  - Read handshake: R_Valid && M_Ready; each one increments rd_cnt.
  - M_Last = M_Valid && (rd_cnt == beats-1).
  - The handshake with M_Last = 1 moves the state to DONE.
- Outside DRAIN: R_Ready = 0 and M_Valid = 0, so the buffer's trailing M_Valid cycle after empty is never consumed.
- DONE: Done = 1 for one cycle; return to IDLE.
- Layer latency (zero-stall case): FILL spends beats cycles, FLUSH 1, WAIT about 2 (buffer-dependent), DRAIN beats cycles, DONE 1.
- Counter wrap: beats = 65536 is represented as 17'h10000; the terminal compare uses beats-1 = 16'hFFFF, so wr_cnt and rd_cnt never wrap.
- Simultaneous Start and Done cycle: Start is rejected with Err, because state is DONE, not IDLE.

Test Plan:
- Reset, then Start with Cfg_Beats=4, Cfg_Src=0; S0 sends 0x1..0x4 with no stalls -> B_Last pulses once after the 4th write; M shows 0x1..0x4 with M_Last only on 0x4; Done pulses once; Busy then falls.
- Cfg_Src=1, Cfg_Beats=3, S0_Valid held high throughout -> S0_Ready stays 0; only S1 data 0xA,0xB,0xC appears on M.
- Cfg_Beats=8 with random B_Ready and M_Ready stalls -> data order preserved, exactly 8 M handshakes, M_Last on the 8th, no drops or duplicates.
- Start with Cfg_Beats=0 -> Err pulses, Busy stays 0; a second Start issued during FILL -> Err pulses, the layer completes unaffected.
- Cfg_Beats=1 -> single beat carries M_Last; Cfg_Beats=65536 -> M_Last on beat 65536, counters do not wrap.
- rst asserted mid-DRAIN after 2 of 5 beats -> IDLE next cycle, all outputs 0; a subsequent clean 2-beat layer completes correctly.
